duty_setter: RTL
================

Name: duty_setter

Overview:
- Upstream stage of the LED PWM/display path. Turns two raw push-buttons (up/down) into the 8-bit duty value `bin` consumed by the LED brightness controller and its 3-digit decimal display.
- Synchronizes and debounces each button, steps the value once per press, and auto-repeats while a button is held.
- Saturates at the range ends.
- Single clock domain; value is registered and held stable between steps.

Parameters:
- DEBOUNCE, 16: consecutive cycles a synchronized input must differ from the debounced level before the debounced level flips (minimum 2).
- REPEAT_DELAY, 64: cycles a button must stay held after its first step before auto-repeat starts.
- REPEAT_RATE, 8: cycles between auto-repeat steps.
- STEP, 1: increment/decrement amount per step (1..255).
- INIT, 0: value loaded into bin on reset.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-low reset (sampled on rising clk; 0 = reset)
- btn_up  input  1  raw up button, active-high, asynchronous to clk
- btn_dn  input  1  raw down button, active-high, asynchronous to clk
- bin  output  8  current duty value, registered
- changed  output  1  one-cycle pulse in the same cycle bin takes a new value
- holding  output  1  high while the FSM is in REP_WAIT or REPEAT

Behaviour:
- Reset (rst=0 at a clk edge), all registers:
  - bin=INIT, changed=0, holding=0.
  - Sync flops=0, debounced levels=0, counters=0, FSM=IDLE.
  - Reset mid-hold aborts the repeat. A button still held after rst returns to 1 is re-debounced and treated as a new press.
- Synchronizer: 2 flops per button. Raw inputs never reach other logic.
- Debouncer, per button:
  - Counter clears whenever the sync output equals the debounced level.
  - Otherwise it increments; when it reaches DEBOUNCE-1 the debounced level flips and the counter clears.
  - Glitches shorter than DEBOUNCE cycles are ignored.
- Step operation:
  - up: bin = min(bin+STEP, 255), computed in 9 bits.
  - down: bin = max(bin-STEP, 0), computed signed 9 bits.
  - changed=1 only if the result differs from the old bin. A step at a saturated end gives no change and no pulse.
- FSM states IDLE, REP_WAIT, REPEAT, LOCK. Let U and D be the debounced levels.
  - IDLE:
    - U rising edge with D=0: step up, go to REP_WAIT, load timer with REPEAT_DELAY-1.
    - D rising edge with U=0: same, stepping down.
    - U and D both 1: go to LOCK.
  - REP_WAIT:
    - Active button released: go to IDLE.
    - Other button becomes 1: go to LOCK, no step.
    - Timer reaches 0: step, go to REPEAT, load timer with REPEAT_RATE-1.
  - REPEAT:
    - Same release and other-button exits as REP_WAIT.
    - Timer reaches 0: step and reload REPEAT_RATE-1.
  - LOCK: no steps; go to IDLE only when U=0 and D=0.
- Latency:
  - Raw rising edge stable from edge k: debounced level flips at edge k+2+DEBOUNCE-1.
  - bin updates at the following edge, i.e. k+DEBOUNCE+2.
  - First repeat step is REPEAT_DELAY cycles after the first step; subsequent steps are every REPEAT_RATE cycles.
- Simultaneous rising edges on U and D in the same cycle: no step, go to LOCK.
- The direction is fixed by the button that entered REP_WAIT.

Optional Feature:
- Macro DUTY_SETTER_WRAP_EN.
- Defined: steps wrap modulo 256 (255+1 gives 0; 0-1 gives 255). changed pulses on every step, since with STEP≥1 a wrap always alters bin.
- Undefined: saturating behaviour as specified above.

Test Plan:
All scenarios use bench overrides DEBOUNCE=4, REPEAT_DELAY=16, REPEAT_RATE=4, STEP=1, INIT=0.
- Reset: hold rst=0 for 3 cycles with btn_up=1 → bin=0, changed=0, holding=0. After release, bin=1 exactly 6 edges later.
- Bounce: btn_up toggles 1/0 every 2 cycles for 20 cycles, then stays 0 → bin stays 0, changed never asserts.
- Single press: btn_up high for 10 cycles → bin 0→1 at edge k+6, single changed pulse, no repeat.
- Auto-repeat: btn_up held 50 cycles from bin=0 → steps at k+6, k+22, k+26, k+30 ... holding=1 from k+6. Release returns to IDLE within DEBOUNCE+2 cycles, with no extra step after the debounced release.
- Saturation/lock:
  - INIT=254, hold btn_up → bin reaches 255, then no further changed pulses.
  - Press btn_dn while holding btn_up → no steps until both are released.
- Wrap (DUTY_SETTER_WRAP_EN defined): INIT=0, single btn_dn press → bin=255, changed pulses once.

Source files
------------

// File: rtl/duty_setter.sv
// duty_setter: turns raw up/down buttons into an 8-bit duty value with debounce and auto-repeat.
// Build with DUTY_SETTER_WRAP_EN defined to make steps wrap modulo 256 instead of saturating.
module duty_setter #(
    parameter int DEBOUNCE     = 16,
    parameter int REPEAT_DELAY = 64,
    parameter int REPEAT_RATE  = 8,
    parameter int STEP         = 1,
    parameter int INIT         = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_dn,
    output logic [7:0] bin,
    output logic       changed,
    output logic       holding
);
    localparam int DW   = $clog2(DEBOUNCE);
    localparam int TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [1:0] {IDLE, REP_WAIT, REPEAT, LOCK} state_t;

    // Bit 0 carries the up button, bit 1 the down button.
    logic [1:0]    raw, sync1, sync2, lvl, lvl_q;
    logic [DW-1:0] cnt [2];
    state_t        state;
    logic          dir;
    logic [TW-1:0] timer;
    logic          up, dn, act, oth, step_dn;
    logic [7:0]    stepped;

    assign raw = {btn_dn, btn_up};

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            lvl <= '0;
            for (int i = 0; i < 2; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == lvl[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DW'(DEBOUNCE - 1)) begin
                    lvl[i] <= ~lvl[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + DW'(1);
                end
            end
        end
    end

    function automatic logic [7:0] step_val(input logic [7:0] v, input logic down);
        logic [8:0]        sum;
        logic signed [8:0] diff;
        sum  = {1'b0, v} + 9'(STEP);
        diff = $signed({1'b0, v}) - $signed(9'(STEP));
`ifdef DUTY_SETTER_WRAP_EN
        step_val = down ? diff[7:0] : sum[7:0];
`else
        if (down) step_val = diff[8] ? 8'h00 : diff[7:0];
        else      step_val = sum[8]  ? 8'hFF : sum[7:0];
`endif
    endfunction

    assign up  = lvl[0];
    assign dn  = lvl[1];
    assign act = dir ? dn : up;
    assign oth = dir ? up : dn;
    // In IDLE a step only happens on a lone press, so the down flag is simply "up not held".
    assign step_dn = (state == IDLE) ? ~up : dir;
    assign stepped = step_val(bin, step_dn);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            dir     <= 1'b0;
            timer   <= '0;
            bin     <= 8'(INIT);
            changed <= 1'b0;
            holding <= 1'b0;
            lvl_q   <= '0;
        end else begin
            lvl_q   <= lvl;
            changed <= 1'b0;
            case (state)
                IDLE: begin
                    if (up && dn) begin
                        state <= LOCK;
                    end else if ((up && !lvl_q[0]) || (dn && !lvl_q[1])) begin
                        bin     <= stepped;
                        changed <= (stepped != bin);
                        dir     <= dn;
                        timer   <= TW'(REPEAT_DELAY - 1);
                        state   <= REP_WAIT;
                        holding <= 1'b1;
                    end
                end
                REP_WAIT, REPEAT: begin
                    if (!act) begin
                        state   <= IDLE;
                        holding <= 1'b0;
                    end else if (oth) begin
                        state   <= LOCK;
                        holding <= 1'b0;
                    end else if (timer == '0) begin
                        bin     <= stepped;
                        changed <= (stepped != bin);
                        timer   <= TW'(REPEAT_RATE - 1);
                        state   <= REPEAT;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                LOCK: begin
                    if (!up && !dn) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
